sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Message-schedule stage of the SHA-256 datapath. Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input.
- Emits the 64 schedule words W0..W63, one per handshake, to the compression round stage.
- Uses the right-rotate and right-shift primitives to build sigma0 and sigma1.
- Holds the block in a 16-entry circular word buffer; no full 64-word store.

Parameters:
- WORD_W, 32, word width; only 32 is supported.
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts in_word; high only in LOAD.
- in_word  input  32  message word; M0 is sent first.
- w_valid  output  1  w_out/w_idx valid; high only in EMIT.
- w_ready  input  1  downstream accepts w_out.
- w_out  output  32  schedule word W[w_idx].
- w_idx  output  6  round index t, 0..63.
- w_last  output  1  high with w_valid when w_idx == 63.
- busy  output  1  high in LOAD after the first word, and in EMIT.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = LOAD; load count = 0; t = 0.
  - in_ready = 1 one cycle after release (registered); w_valid = 0; w_last = 0; w_idx = 0; w_out = 0; busy = 0.
  - Buffer contents are don't-care; the bench must not observe them.
- States: LOAD, EMIT. There is no separate idle state; LOAD with count 0 is idle.
- LOAD:
  - Each cycle with in_valid & in_ready writes buf[cnt] = in_word and increments cnt.
  - On the 16th accept (cnt == 15): go to EMIT, drop in_ready next cycle, t = 0.
  - in_valid gaps simply stall loading.
- EMIT:
  - w_valid = 1.
  - For t < 16: w_out = buf[t].
  - For t >= 16: w_out = sigma1(buf[(t-2)&15]) + buf[(t-7)&15] + sigma0(buf[(t-15)&15]) + buf[t&15], modulo 2^32.
    - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
    - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - w_out is a combinational function of registered buffer state and t.
  - On w_valid & w_ready:
    - If t >= 16, buf[t&15] is overwritten with w_out.
    - t increments.
- Backpressure: while w_valid & !w_ready, w_out, w_idx and w_last are held stable and the buffer is not written.
- Last word: the handshake at t = 63 returns the block to LOAD with cnt = 0. in_ready rises the next cycle.
- Input side: in_ready = 0 throughout EMIT. in_valid there is ignored and no word is consumed.
- Latency:
  - The first W0 is valid in the cycle after the 16th input accept.
  - With w_ready held high, one word per cycle: 64 cycles per block.
  - Block-to-block gap is at least 16 load cycles.
- Reset mid-operation (LOAD or EMIT): immediate abort to the reset state. The partial block is discarded, no further w_valid is produced, and the next block starts from M0.
- Single in-flight block. No overlap of loading the next block with emitting the current one.

Test Plan:
- NIST "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), w_ready held 1 -> W16 = 0x61626380, W17 = 0x000F0000, W63 = 0x12B1EDEB. w_last is high only at idx 63. in_ready returns 1 one cycle after the final handshake.
- Same block with w_ready toggled pseudo-randomly, including a 5-cycle stall at t = 16 -> identical W sequence; w_out/w_idx stable throughout the stall; exactly 64 handshakes.
- All words 0xFFFFFFFF -> W16 = sigma1(0xFFFFFFFF) + 0xFFFFFFFF + sigma0(0xFFFFFFFF) + 0xFFFFFFFF computed mod 2^32 (carries dropped), matched against the C reference model for all 64 words.
- in_valid with 3-cycle gaps during LOAD -> no word is dropped or duplicated; W0..W15 equal the inputs in order. in_valid held high during EMIT -> no input is consumed.
- reset asserted asynchronously (mid-cycle) at t = 30, then released, followed by a fresh "abc" block -> w_valid = 0 immediately on assertion; the next output stream is correct from W0.
- Two back-to-back blocks ("abc", then the all-zero block) -> the second stream is W0..W15 = 0 and all W = 0. No state leaks from the first block.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha256_msg_schedule
// Message-schedule stage of the SHA-256 datapath. One 512-bit block is loaded
// as 16 big-endian words (M0 first) and the 64 schedule words W0..W63 are
// emitted one per handshake. Only a 16-entry circular buffer is kept: each
// newly computed W[t] overwrites buf[t&15], which is the slot W[t-16] used.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_valid  in_word is valid
//   in_ready  block accepts in_word (registered; high only in LOAD)
//   in_word   message word
//   w_valid   w_out/w_idx valid (high only in EMIT)
//   w_ready   downstream accepts w_out
//   w_out     schedule word W[w_idx]
//   w_idx     round index 0..63
//   w_last    high with w_valid at w_idx == 63
//   busy      high in LOAD after the first word and throughout EMIT
// ---------------------------------------------------------------------------
module sha256_msg_schedule #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [WORD_W-1:0] w_out,
   output logic [5:0]        w_idx,
   output logic              w_last,
   output logic              busy
);

   typedef enum logic {S_LOAD, S_EMIT} state_t;

   localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      rotr = (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  t_q, t_d;
   logic        in_ready_q;
   logic [31:0] wbuf [16];

   logic        accept;
   logic        fire;
   logic        buf_we;
   logic [3:0]  buf_waddr;
   logic [31:0] buf_wdata;
   logic [31:0] sched_word;
   logic [31:0] cur_word;
   logic [3:0]  tl;

   assign tl     = t_q[3:0];
   assign accept = (state_q == S_LOAD) && in_ready_q && in_valid;
   assign fire   = (state_q == S_EMIT) && w_ready;

   // 4-bit index arithmetic wraps naturally onto the circular buffer.
   assign sched_word = sig1(wbuf[tl - 4'd2]) + wbuf[tl - 4'd7]
                     + sig0(wbuf[tl - 4'd15]) + wbuf[tl];
   assign cur_word   = (t_q[5:4] == 2'b00) ? wbuf[tl] : sched_word;

   assign in_ready = in_ready_q;
   assign w_valid  = (state_q == S_EMIT);
   assign w_out    = (state_q == S_EMIT) ? WORD_W'(cur_word) : '0;
   assign w_idx    = t_q;
   assign w_last   = (state_q == S_EMIT) && (t_q == T_LAST);
   assign busy     = (state_q == S_EMIT) || (cnt_q != 4'd0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      t_d       = t_q;
      buf_we    = 1'b0;
      buf_waddr = cnt_q;
      buf_wdata = 32'(in_word);
      case (state_q)
         S_LOAD: begin
            if (accept) begin
               buf_we = 1'b1;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = S_EMIT;
                  t_d     = '0;
               end
            end
         end
         S_EMIT: begin
            if (fire) begin
               if (t_q[5:4] != 2'b00) begin
                  buf_we    = 1'b1;
                  buf_waddr = tl;
                  buf_wdata = sched_word;
               end
               if (t_q == T_LAST) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
                  t_d     = '0;
               end else begin
                  t_d = t_q + 6'd1;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_LOAD;
         cnt_q      <= '0;
         t_q        <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         t_q        <= t_d;
         in_ready_q <= (state_d == S_LOAD);
      end
   end

   // Buffer holds no reset: its contents are only read after a full load.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         wbuf[buf_waddr] <= buf_wdata;
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Directed bench for sha256_msg_schedule. Inputs are driven on the falling
// edge, outputs are sampled there as well. Expected schedules come from an
// independent 64-entry reference expansion plus hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sha256_msg_schedule;

   typedef logic [31:0] blk_t [16];
   typedef logic [31:0] sched_t [64];

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_word = '0;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [31:0] w_out;
   logic [5:0]  w_idx;
   logic        w_last;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sha256_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_word  (in_word),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_out    (w_out),
      .w_idx    (w_idx),
      .w_last   (w_last),
      .busy     (busy)
   );

   function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
      m_rotr = (x >> n) | (x << (32 - n));
   endfunction

   task automatic ref_sched(input blk_t m, output sched_t w);
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) w[i] = m[i];
      for (int i = 16; i < 64; i++) begin
         s0 = m_rotr(w[i-15], 7) ^ m_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = m_rotr(w[i-2], 17) ^ m_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
   endtask

   task automatic abc_block(output blk_t m);
      for (int i = 0; i < 16; i++) m[i] = '0;
      m[0]  = 32'h61626380;
      m[15] = 32'h00000018;
   endtask

   // Drives 16 words with 'gap' idle cycles after each accept. Returns just
   // after the edge that takes the 16th word.
   task automatic load_block(input blk_t m, input int gap, input bit hold_valid, output bit tmo);
      int i;
      int guard;
      i = 0;
      guard = 0;
      tmo = 1'b0;
      while (i < 16 && !tmo) begin
         @(negedge clk);
         guard++;
         if (guard > 1000) tmo = 1'b1;
         in_valid = 1'b1;
         in_word  = m[i];
         if (in_ready && !tmo) begin
            @(posedge clk);
            i++;
            for (int g = 0; g < gap && i < 16; g++) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_word  = 32'hDEADBEEF;
            end
         end
      end
      #1;
      in_valid = hold_valid;
      in_word  = 32'hA5A5A5A5;
   endtask

   // mode 0: w_ready held high; mode 1: random w_ready with a 5-cycle stall at t=16.
   task automatic collect(input int mode, output sched_t got, output int nhs, output int lastbad,
                          output int stabbad, output int rdybad, output bit tmo);
      int guard;
      int stall16;
      bit prev_stall;
      bit done;
      logic [31:0] pw;
      logic [5:0]  pi;
      guard = 0; stall16 = 0; prev_stall = 0; done = 0;
      nhs = 0; lastbad = 0; stabbad = 0; rdybad = 0; tmo = 0;
      pw = '0; pi = '0;
      for (int k = 0; k < 64; k++) got[k] = 'x;
      while (!done && !tmo) begin
         @(negedge clk);
         guard++;
         if (guard > 3000) tmo = 1'b1;
         if (mode == 0) w_ready = 1'b1;
         else if (w_valid && w_idx == 6'd16 && stall16 < 5) begin
            w_ready = 1'b0;
            stall16++;
         end else w_ready = 1'($urandom_range(0, 1));
         if (w_valid) begin
            if (in_ready) rdybad++;
            if (w_last !== (w_idx == 6'd63)) lastbad++;
            if (prev_stall && (w_out !== pw || w_idx !== pi)) stabbad++;
            if (w_ready) begin
               got[w_idx] = w_out;
               nhs++;
               if (w_idx == 6'd63) done = 1'b1;
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               pw = w_out;
               pi = w_idx;
            end
         end else begin
            if (w_last) lastbad++;
            prev_stall = 1'b0;
         end
      end
      if (stall16 != 5 && mode == 1) stabbad += 100;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if (w_valid !== 1'b0 || w_last !== 1'b0 || w_idx !== 6'd0 || w_out !== 32'd0 ||
          busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b l=%b i=%0d o=%h b=%b r=%b want all 0",
                  w_valid, w_last, w_idx, w_out, busy, in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_after_release: got r=%b v=%b want r=1 v=0", in_ready, w_valid);
      end
   endtask

   task automatic compare_sched(input string name, input sched_t got, input sched_t exp);
      for (int k = 0; k < 64; k++) begin
         vectors++;
         if (got[k] !== exp[k]) begin
            miscompares++;
            $display("FAIL %s W%0d: got %h want %h", name, k, got[k], exp[k]);
         end
      end
   endtask

   task automatic test_abc();
      blk_t m; sched_t exp, got;
      int nhs, lastbad, stabbad, rdybad; bit tmo;
      abc_block(m);
      ref_sched(m, exp);
      w_ready = 1'b0;
      load_block(m, 0, 1'b0, tmo);
      @(negedge clk);
      vectors++;
      if (tmo || w_valid !== 1'b1 || w_idx !== 6'd0 || w_out !== 32'h61626380 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL abc_first_word: got tmo=%b v=%b i=%0d o=%h r=%b want v=1 i=0 o=61626380 r=0",
                  tmo, w_valid, w_idx, w_out, in_ready);
      end
      collect(0, got, nhs, lastbad, stabbad, rdybad, tmo);
      vectors++;
      if (got[16] !== 32'h61626380 || got[17] !== 32'h000F0000 || got[63] !== 32'h12B1EDEB) begin
         miscompares++;
         $display("FAIL abc_known: got W16=%h W17=%h W63=%h want 61626380 000f0000 12b1edeb",
                  got[16], got[17], got[63]);
      end
      compare_sched("abc", got, exp);
      vectors++;
      if (tmo || nhs != 64 || lastbad != 0 || rdybad != 0) begin
         miscompares++;
         $display("FAIL abc_handshakes: got tmo=%b hs=%0d lastbad=%0d rdybad=%0d want 0 64 0 0",
                  tmo, nhs, lastbad, rdybad);
      end
      vectors++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abc_return_load: got r=%b v=%b b=%b want 1 0 0", in_ready, w_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      blk_t m; sched_t exp, got;
      int nhs, lastbad, stabbad, rdybad; bit tmo, tmo2;
      abc_block(m);
      ref_sched(m, exp);
      load_block(m, 0, 1'b0, tmo);
      collect(1, got, nhs, lastbad, stabbad, rdybad, tmo2);
      compare_sched("bp", got, exp);
      vectors++;
      if (tmo || tmo2 || nhs != 64 || stabbad != 0 || lastbad != 0) begin
         miscompares++;
         $display("FAIL bp_stall: got tmo=%b hs=%0d stabbad=%0d lastbad=%0d want 0 64 0 0",
                  tmo | tmo2, nhs, stabbad, lastbad);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (w_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_no_extra: got w_valid=%b want 0", w_valid);
      end
   endtask

   task automatic test_all_ones();
      blk_t m; sched_t exp, got;
      int nhs, lastbad, stabbad, rdybad; bit tmo, tmo2;
      for (int i = 0; i < 16; i++) m[i] = 32'hFFFFFFFF;
      ref_sched(m, exp);
      load_block(m, 0, 1'b0, tmo);
      collect(0, got, nhs, lastbad, stabbad, rdybad, tmo2);
      vectors++;
      if (tmo || tmo2 || got[16] !== 32'h203FFFFC) begin
         miscompares++;
         $display("FAIL ones_w16: got %h want 203ffffc", got[16]);
      end
      compare_sched("ones", got, exp);
   endtask

   task automatic test_gaps();
      blk_t m; sched_t exp, got;
      int nhs, lastbad, stabbad, rdybad; bit tmo, tmo2;
      for (int i = 0; i < 16; i++) m[i] = 32'h01234567 + 32'(i) * 32'h11111111;
      ref_sched(m, exp);
      load_block(m, 3, 1'b1, tmo);
      collect(0, got, nhs, lastbad, stabbad, rdybad, tmo2);
      in_valid = 1'b0;
      compare_sched("gaps", got, exp);
      vectors++;
      if (tmo || tmo2 || rdybad != 0 || nhs != 64) begin
         miscompares++;
         $display("FAIL gaps_emit_ready: got tmo=%b rdybad=%0d hs=%0d want 0 0 64", tmo | tmo2, rdybad, nhs);
      end
   endtask

   task automatic test_reset_mid();
      blk_t m; sched_t exp, got;
      int nhs, lastbad, stabbad, rdybad, guard; bit tmo, tmo2;
      abc_block(m);
      ref_sched(m, exp);
      load_block(m, 0, 1'b0, tmo);
      guard = 0;
      do begin
         @(negedge clk);
         w_ready = 1'b1;
         guard++;
      end while (!(w_valid && w_idx == 6'd30) && guard < 200);
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if (guard >= 200 || w_valid !== 1'b0 || w_idx !== 6'd0 || w_out !== 32'd0 ||
          busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_abort: got guard=%0d v=%b i=%0d o=%h b=%b r=%b want v=0 i=0 o=0 b=0 r=0",
                  guard, w_valid, w_idx, w_out, busy, in_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_release: got r=%b v=%b want 1 0", in_ready, w_valid);
      end
      load_block(m, 0, 1'b0, tmo);
      collect(0, got, nhs, lastbad, stabbad, rdybad, tmo2);
      compare_sched("midreset", got, exp);
      vectors++;
      if (tmo || tmo2 || nhs != 64) begin
         miscompares++;
         $display("FAIL midreset_hs: got tmo=%b hs=%0d want 0 64", tmo | tmo2, nhs);
      end
   endtask

   task automatic test_back_to_back();
      blk_t m, z; sched_t exp_a, exp_z, got_a, got_z;
      int nhs, lastbad, stabbad, rdybad; bit t1, t2, t3, t4;
      abc_block(m);
      for (int i = 0; i < 16; i++) z[i] = '0;
      ref_sched(m, exp_a);
      for (int k = 0; k < 64; k++) exp_z[k] = '0;
      load_block(m, 0, 1'b0, t1);
      collect(0, got_a, nhs, lastbad, stabbad, rdybad, t2);
      load_block(z, 0, 1'b0, t3);
      collect(0, got_z, nhs, lastbad, stabbad, rdybad, t4);
      compare_sched("b2b_abc", got_a, exp_a);
      compare_sched("b2b_zero", got_z, exp_z);
      vectors++;
      if (t1 || t2 || t3 || t4 || nhs != 64) begin
         miscompares++;
         $display("FAIL b2b_timeout: got tmo=%b hs=%0d want 0 64", t1 | t2 | t3 | t4, nhs);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_all_ones();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
